// File: rtl/spi_receiver_pkg.sv
// rtl/spi_receiver_pkg.sv - shared types for the SPI receiver
package spi_receiver_pkg;

  typedef logic [7:0] byte_t;

  localparam int SPI_BITS = 8;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_LOW,
    SHIFT
  } rx_state_t;

endpackage

// File: rtl/spi_receiver_fifo.sv
// rtl/spi_receiver_fifo.sv - first-word-fall-through byte buffer
// A push while full is only accepted when a pop frees the head slot in the same cycle.
module byte_fifo
  import spi_receiver_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  byte_t                    push_data,
  input  logic                     pop,
  output byte_t                    pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  byte_t         mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign empty    = (cnt == '0);
  assign full     = (cnt == (AW+1)'(DEPTH));
  assign count    = cnt;
  assign pop_data = mem[rd_ptr];
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/spi_receiver.sv
// rtl/spi_receiver.sv - oversampling SPI byte receiver with FIFO and valid/ready output
module spi_receiver
  import spi_receiver_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       mosi,
  input  logic       cs,
  output byte_t      data_out,
  output logic       valid,
  input  logic       ready,
  output logic       frame_active,
  output logic [7:0] byte_cnt,
  output logic       overrun,
  output logic       frame_err,
  input  logic       clr_err
);

  localparam logic [2:0] LAST_BIT = 3'(SPI_BITS - 1);

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] sync_fill;
  logic                   sclk_s, mosi_s, cs_s;
  logic                   sclk_d, cs_d;
  logic                   rise_sclk, cs_fall, cs_rise;
  logic                   cs_armed;

  rx_state_t  state, state_n;
  byte_t      shreg;
  logic [2:0] bit_cnt;
  logic       start_frame, shift_en, drop_partial, err_set;
  logic       push_req, pop, fifo_full, fifo_empty, overrun_set;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign rise_sclk = sclk_s && !sclk_d;
  assign cs_fall   = !cs_s && cs_d;
  assign cs_rise   = cs_s && !cs_d;

  // sync_fill marks when cs_s reflects the pin rather than the reset value, so a cs
  // held low through reset release cannot look like a fresh falling edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_sync <= '1;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sync_fill <= '0;
      sclk_d    <= 1'b1;
      cs_d      <= 1'b1;
      cs_armed  <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sync_fill <= {sync_fill[SYNC_STAGES-2:0], 1'b1};
      sclk_d    <= sclk_s;
      cs_d      <= cs_s;
      cs_armed  <= cs_armed || (sync_fill[SYNC_STAGES-1] && cs_s);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n      = state;
    start_frame  = 1'b0;
    shift_en     = 1'b0;
    drop_partial = 1'b0;
    err_set      = 1'b0;
    if (state != IDLE && cs_rise) begin
      state_n      = IDLE;
      drop_partial = 1'b1;
      // A lone bit with sclk high is the transmitter's closing clock edge, not data.
      if (bit_cnt >= 3'd2)                   err_set = 1'b1;
      else if (bit_cnt == 3'd1 && !sclk_s)   err_set = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (cs_fall && cs_armed) begin
            state_n     = WAIT_LOW;
            start_frame = 1'b1;
          end
        end
        WAIT_LOW: if (!sclk_s) state_n = SHIFT;
        SHIFT:    if (rise_sclk) shift_en = 1'b1;
        default:  state_n = IDLE;
      endcase
    end
  end

  assign push_req    = shift_en && (bit_cnt == LAST_BIT);
  assign pop         = valid && ready;
  assign overrun_set = push_req && fifo_full && !pop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg    <= '0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
    end else if (start_frame) begin
      shreg    <= '0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
    end else if (drop_partial) begin
      bit_cnt  <= '0;
    end else if (shift_en) begin
      shreg <= {shreg[6:0], mosi_s};
      if (bit_cnt == LAST_BIT) begin
        bit_cnt <= '0;
        if (byte_cnt != 8'hFF) byte_cnt <= byte_cnt + 1'b1;
      end else begin
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (overrun_set)  overrun <= 1'b1;
      else if (clr_err) overrun <= 1'b0;
      if (err_set)      frame_err <= 1'b1;
      else if (clr_err) frame_err <= 1'b0;
    end
  end

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_req),
    .push_data ({shreg[6:0], mosi_s}),
    .pop       (pop),
    .pop_data  (data_out),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign valid        = !fifo_empty;
  assign frame_active = (state != IDLE);

  a_valid_count: assert property (@(posedge clk) disable iff (!rst) valid == (fifo_count != '0));

endmodule

// File: tb/tb_spi_receiver.sv
// tb/tb_spi_receiver.sv - directed self-checking bench for spi_receiver
module tb_spi_receiver;

  logic       clk = 1'b0;
  logic       rst;
  logic       sclk, mosi, cs, ready, clr_err;
  logic [7:0] data_out;
  logic       valid, frame_active, overrun, frame_err;
  logic [7:0] byte_cnt;

  int         total = 0;
  int         bad   = 0;
  logic [7:0] rxq[$];

  spi_receiver #(.SYNC_STAGES(2), .FIFO_DEPTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .sclk         (sclk),
    .mosi         (mosi),
    .cs           (cs),
    .data_out     (data_out),
    .valid        (valid),
    .ready        (ready),
    .frame_active (frame_active),
    .byte_cnt     (byte_cnt),
    .overrun      (overrun),
    .frame_err    (frame_err),
    .clr_err      (clr_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rst && valid && ready) rxq.push_back(data_out);

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    sclk = 1'b0; mosi = b; wait_clk(8);
    sclk = 1'b1;           wait_clk(8);
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic start_frame();
    cs = 1'b0; wait_clk(8);
  endtask

  task automatic end_frame(input logic eof_clock);
    if (eof_clock) begin
      sclk = 1'b0; wait_clk(8);
      sclk = 1'b1; wait_clk(8);
    end
    cs = 1'b1; wait_clk(8);
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1; wait_clk(1);
    clr_err = 1'b0; wait_clk(2);
  endtask

  task automatic test_reset();
    wait_clk(3);
    total++; if (valid !== 1'b0)        begin bad++; $display("FAIL reset_valid got=%h want=0", valid); end
    total++; if (data_out !== 8'h00)    begin bad++; $display("FAIL reset_data got=%h want=00", data_out); end
    total++; if (frame_active !== 1'b0) begin bad++; $display("FAIL reset_active got=%h want=0", frame_active); end
    total++; if (byte_cnt !== 8'h00)    begin bad++; $display("FAIL reset_byte_cnt got=%h want=00", byte_cnt); end
    total++; if (overrun !== 1'b0)      begin bad++; $display("FAIL reset_overrun got=%h want=0", overrun); end
    total++; if (frame_err !== 1'b0)    begin bad++; $display("FAIL reset_frame_err got=%h want=0", frame_err); end
    rst = 1'b1;
    wait_clk(6);
    total++; if (frame_active !== 1'b0) begin bad++; $display("FAIL post_reset_active got=%h want=0", frame_active); end
  endtask

  task automatic test_single_byte();
    ready = 1'b1; rxq.delete();
    start_frame();
    total++; if (frame_active !== 1'b1) begin bad++; $display("FAIL single_active got=%h want=1", frame_active); end
    send_byte(8'hA5);
    end_frame(1'b0);
    total++; if (rxq.size() !== 1)      begin bad++; $display("FAIL single_count got=%0d want=1", rxq.size()); end
    else begin
      total++; if (rxq[0] !== 8'hA5)    begin bad++; $display("FAIL single_data got=%h want=a5", rxq[0]); end
    end
    total++; if (byte_cnt !== 8'd1)     begin bad++; $display("FAIL single_byte_cnt got=%0d want=1", byte_cnt); end
    total++; if (frame_err !== 1'b0)    begin bad++; $display("FAIL single_frame_err got=%h want=0", frame_err); end
    total++; if (frame_active !== 1'b0) begin bad++; $display("FAIL single_idle got=%h want=0", frame_active); end
  endtask

  task automatic test_eof_shape();
    ready = 1'b1; rxq.delete();
    start_frame();
    send_byte(8'hAE);
    send_byte(8'h3C);
    end_frame(1'b1);
    total++; if (rxq.size() !== 2)   begin bad++; $display("FAIL eof_count got=%0d want=2", rxq.size()); end
    else begin
      total++; if (rxq[0] !== 8'hAE) begin bad++; $display("FAIL eof_byte0 got=%h want=ae", rxq[0]); end
      total++; if (rxq[1] !== 8'h3C) begin bad++; $display("FAIL eof_byte1 got=%h want=3c", rxq[1]); end
    end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL eof_frame_err got=%h want=0", frame_err); end
    total++; if (byte_cnt !== 8'd2)  begin bad++; $display("FAIL eof_byte_cnt got=%0d want=2", byte_cnt); end
  endtask

  task automatic test_partial();
    ready = 1'b1; rxq.delete();
    start_frame();
    for (int i = 0; i < 5; i++) send_bit(i[0]);
    end_frame(1'b0);
    total++; if (rxq.size() !== 0)   begin bad++; $display("FAIL partial_count got=%0d want=0", rxq.size()); end
    total++; if (frame_err !== 1'b1) begin bad++; $display("FAIL partial_frame_err got=%h want=1", frame_err); end
    total++; if (byte_cnt !== 8'd0)  begin bad++; $display("FAIL partial_byte_cnt got=%0d want=0", byte_cnt); end
    pulse_clr();
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL partial_clr got=%h want=0", frame_err); end
  endtask

  task automatic test_overrun();
    ready = 1'b0; rxq.delete();
    start_frame();
    for (int i = 1; i <= 5; i++) send_byte(8'(i));
    end_frame(1'b0);
    total++; if (valid !== 1'b1)      begin bad++; $display("FAIL ovr_valid got=%h want=1", valid); end
    total++; if (data_out !== 8'h01)  begin bad++; $display("FAIL ovr_head got=%h want=01", data_out); end
    total++; if (overrun !== 1'b1)    begin bad++; $display("FAIL ovr_flag got=%h want=1", overrun); end
    total++; if (byte_cnt !== 8'd5)   begin bad++; $display("FAIL ovr_byte_cnt got=%0d want=5", byte_cnt); end
    ready = 1'b1; wait_clk(10);
    total++; if (rxq.size() !== 4)    begin bad++; $display("FAIL ovr_pops got=%0d want=4", rxq.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        total++; if (rxq[i] !== 8'(i + 1)) begin bad++; $display("FAIL ovr_order%0d got=%h want=%h", i, rxq[i], 8'(i + 1)); end
      end
    end
    total++; if (valid !== 1'b0)      begin bad++; $display("FAIL ovr_drained got=%h want=0", valid); end
    pulse_clr();
    total++; if (overrun !== 1'b0)    begin bad++; $display("FAIL ovr_clr got=%h want=0", overrun); end
  endtask

  task automatic test_full_pop();
    logic [7:0] b;
    ready = 1'b0; rxq.delete();
    start_frame();
    for (int i = 0; i < 4; i++) send_byte(8'h10 + 8'(i));
    b = 8'h14;
    for (int i = 7; i >= 1; i--) send_bit(b[i]);
    sclk = 1'b0; mosi = b[0]; wait_clk(8);
    // The push lands on the third clk edge after the sclk pin rises; pop on exactly that edge.
    sclk = 1'b1; wait_clk(2);
    ready = 1'b1; wait_clk(1);
    ready = 1'b0; wait_clk(5);
    total++; if (overrun !== 1'b0)   begin bad++; $display("FAIL fullpop_overrun got=%h want=0", overrun); end
    total++; if (rxq.size() !== 1)   begin bad++; $display("FAIL fullpop_one_pop got=%0d want=1", rxq.size()); end
    end_frame(1'b0);
    ready = 1'b1; wait_clk(10);
    total++; if (rxq.size() !== 5)   begin bad++; $display("FAIL fullpop_total got=%0d want=5", rxq.size()); end
    else begin
      for (int i = 0; i < 5; i++) begin
        total++; if (rxq[i] !== 8'h10 + 8'(i)) begin bad++; $display("FAIL fullpop_order%0d got=%h want=%h", i, rxq[i], 8'h10 + 8'(i)); end
      end
    end
  endtask

  task automatic test_reset_midframe();
    ready = 1'b1; rxq.delete();
    start_frame();
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    rst = 1'b0; wait_clk(3);
    rst = 1'b1; wait_clk(3);
    for (int i = 0; i < 5; i++) send_bit(1'b0);
    total++; if (rxq.size() !== 0)      begin bad++; $display("FAIL rstmid_count got=%0d want=0", rxq.size()); end
    total++; if (frame_active !== 1'b0) begin bad++; $display("FAIL rstmid_active got=%h want=0", frame_active); end
    end_frame(1'b0);
    total++; if (frame_err !== 1'b0)    begin bad++; $display("FAIL rstmid_frame_err got=%h want=0", frame_err); end
    ready = 1'b0;
    start_frame();
    send_byte(8'h81);
    end_frame(1'b0);
    total++; if (valid !== 1'b1)        begin bad++; $display("FAIL rstmid_valid got=%h want=1", valid); end
    total++; if (data_out !== 8'h81)    begin bad++; $display("FAIL rstmid_data got=%h want=81", data_out); end
    ready = 1'b1; wait_clk(3);
    total++; if (rxq.size() !== 1)      begin bad++; $display("FAIL rstmid_pops got=%0d want=1", rxq.size()); end
  endtask

  initial begin
    rst = 1'b0; sclk = 1'b1; cs = 1'b1; mosi = 1'b0; ready = 1'b0; clr_err = 1'b0;
    test_reset();
    test_single_byte();
    test_eof_shape();
    test_partial();
    test_overrun();
    test_full_pop();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
